// File: rtl/imem_boot_loader.sv
// Boot-time loader for the MIPS instruction memory. It streams words into addresses 0.., pads the rest with NOPs, then releases the core.
// Optional: define IMEM_BOOT_CHECKSUM_EN to add a running checksum of the accepted words.
module imem_boot_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 40
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] load_len,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_run,
   output logic              done,
   output logic              error,
`ifdef IMEM_BOOT_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic [1:0]        dbg_state
);

   // Stream handshake: a word transfers on a rising edge where in_valid & in_ready.
   // in_ready depends only on state, never on in_valid.
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FILL = 2'd2, RUN = 2'd3} state_t;

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, rem_q, rem_d, ptr_inc;
   logic              we_d, done_d, error_d, len_ok, hs;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
   assign checksum = sum_q;
`endif

   assign in_ready  = (state_q == LOAD) && (rem_q != '0);
   assign cpu_hold  = (state_q != RUN);
   assign cpu_run   = (state_q == RUN);
   assign dbg_state = state_q;
   assign len_ok    = (load_len != '0) && (load_len <= DEPTH_A);
   assign hs        = in_valid && in_ready;
   assign ptr_inc   = ptr_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      we_d    = 1'b0;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      done_d  = 1'b0;
      error_d = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         IDLE, RUN: begin
            if (start) begin
               if (len_ok) begin
                  state_d = LOAD;
                  ptr_d   = '0;
                  rem_d   = load_len;
`ifdef IMEM_BOOT_CHECKSUM_EN
                  sum_d   = '0;
`endif
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (hs) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = in_data;
               ptr_d   = ptr_inc;
               rem_d   = rem_q - 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
               sum_d   = sum_q + in_data;
`endif
               if (rem_q == ADDR_W'(1) && ptr_inc < DEPTH_A) state_d = FILL;
            end else if (rem_q == '0) begin
               // Full-depth image: release only after the last write has reached memory.
               state_d = RUN;
               done_d  = 1'b1;
            end
         end
         FILL: begin
            if (ptr_q < DEPTH_A) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = '0;
               ptr_d   = ptr_inc;
            end else begin
               state_d = RUN;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         mem_we    <= we_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         done      <= done_d;
         error     <= error_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: captures every memory write and compares the image against hand-built expectations.
module tb_imem_boot_loader;
   localparam int DEPTH = 40;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  load_len = '0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, mem_we, cpu_hold, cpu_run, done, error;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  dbg_state;
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   imem_boot_loader dut (
      .clock(clock), .reset_n(reset_n), .start(start), .load_len(load_len),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .cpu_run(cpu_run), .done(done), .error(error),
`ifdef IMEM_BOOT_CHECKSUM_EN
      .checksum(checksum),
`endif
      .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   logic [31:0] wbuf [DEPTH];
   logic [9:0]  got_addr_q[$];
   logic [31:0] got_data_q[$];
   logic [31:0] exp_q[$];
   int ready_bad = 0, addr_bad = 0, fill_cnt = 0, error_cnt = 0;
   int done_cyc, hs_last;
   logic c1_hold, c1_run;

   always @(negedge clock) begin
      if (reset_n) begin
         if (mem_we) begin
            got_addr_q.push_back(mem_addr);
            got_data_q.push_back(mem_wdata);
            if (mem_addr >= 10'(DEPTH)) addr_bad++;
         end
         if (in_ready && dbg_state != 2'd1) ready_bad++;
         if (dbg_state == 2'd2) fill_cnt++;
         if (error) error_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      #2;
      reset_n = 1'b1;
      step();
   endtask

   // Start a load of len words from wbuf in cycle 0; done_cyc is the first cycle with done high.
   task automatic do_load(input int len, input bit toggle);
      int  idx;
      bit  hs;
      idx = 0;
      hs = 0;
      done_cyc = -1;
      hs_last = -1;
      got_addr_q.delete();
      got_data_q.delete();
      start = 1'b1;
      load_len = 10'(len);
      in_valid = 1'b0;
      for (int cyc = 1; cyc <= 150; cyc++) begin
         step();
         if (cyc == 1) begin
            start = 1'b0;
            c1_hold = cpu_hold;
            c1_run = cpu_run;
         end
         if (hs) begin
            idx++;
            hs_last = cyc - 1;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         hs = 0;
         if (idx < len) begin
            in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
            in_data = wbuf[idx];
            hs = in_valid && in_ready;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic verify_image(input string tag, input int len);
      logic [31:0] e;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(i < len ? wbuf[i] : 32'h0);
      chk({tag, "_nwrites"}, got_addr_q.size(), DEPTH);
      for (int i = 0; i < got_addr_q.size() && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         chk({tag, "_addr"}, 32'(got_addr_q[i]), i);
         chk({tag, "_data"}, got_data_q[i], e);
      end
   endtask

   initial begin
      int err0;
      // Reset values
      #3;
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_cpu_run", cpu_run, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_state", dbg_state, 0);
      @(negedge clock);
      reset_n = 1'b1;
      step();

      // Short program, continuous valid: 3 words then 37 NOPs
      wbuf[0] = 32'h2008_0005;
      wbuf[1] = 32'h2009_0007;
      wbuf[2] = 32'h0109_5020;
      do_load(3, 1'b0);
      chk("t1_done_cycle", done_cyc, 42);
      chk("t1_hold_at_done", cpu_hold, 0);
      chk("t1_run_at_done", cpu_run, 1);
      chk("t1_hold_during_load", c1_hold, 1);
      verify_image("t1", 3);
      step();
      chk("t1_done_pulse_width", done, 0);
      chk("t1_still_run", cpu_run, 1);

      // Full-depth image with gapped valid: no padding phase
      for (int i = 0; i < DEPTH; i++) wbuf[i] = 32'h1000_0000 + 32'(i * 3);
      fill_cnt = 0;
      do_load(DEPTH, 1'b1);
      chk("t2_last_hs_cycle", hs_last, 79);
      chk("t2_done_cycle", done_cyc, 81);
      chk("t2_fill_cycles", fill_cnt, 0);
      verify_image("t2", DEPTH);

      // Rejected starts in IDLE
      do_reset();
      err0 = error_cnt;
      got_addr_q.delete();
      start = 1'b1;
      load_len = 10'd0;
      step();
      start = 1'b0;
      chk("t3_err_len0", error, 1);
      chk("t3_state_len0", dbg_state, 0);
      chk("t3_hold_len0", cpu_hold, 1);
      step();
      chk("t3_err_len0_clear", error, 0);
      start = 1'b1;
      load_len = 10'd41;
      step();
      start = 1'b0;
      chk("t3_err_len41", error, 1);
      chk("t3_state_len41", dbg_state, 0);
      step();
      step();
      chk("t3_error_pulses", error_cnt - err0, 2);
      chk("t3_no_writes", got_addr_q.size(), 0);
      chk("t3_hold_idle", cpu_hold, 1);

      // Reload from RUN, including a rejected start while running
      wbuf[0] = 32'h2008_0005;
      wbuf[1] = 32'h2009_0007;
      wbuf[2] = 32'h0109_5020;
      do_load(3, 1'b0);
      chk("t4_first_done", done_cyc, 42);
      start = 1'b1;
      load_len = 10'd41;
      step();
      start = 1'b0;
      chk("t4_run_err", error, 1);
      chk("t4_run_err_state", dbg_state, 3);
      chk("t4_run_err_cpu_run", cpu_run, 1);
      step();
      wbuf[0] = 32'hFFFF_FFFF;
      do_load(1, 1'b0);
      chk("t4_run_drop", c1_run, 0);
      chk("t4_hold_rise", c1_hold, 1);
      chk("t4_done_cycle", done_cyc, 42);
      verify_image("t4", 1);

      // Asynchronous reset mid-load after two words
      wbuf[0] = 32'hAAAA_0001;
      wbuf[1] = 32'hBBBB_0002;
      start = 1'b1;
      load_len = 10'd5;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = wbuf[0];
      step();
      in_data = wbuf[1];
      step();
      in_valid = 1'b0;
      chk("t5_write_before_rst", mem_we, 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_mem_we", mem_we, 0);
      chk("t5_rst_mem_addr", mem_addr, 0);
      chk("t5_rst_hold", cpu_hold, 1);
      chk("t5_rst_ready", in_ready, 0);
      chk("t5_rst_state", dbg_state, 0);
      #1;
      reset_n = 1'b1;
      step();
      wbuf[0] = 32'h1234_5678;
      wbuf[1] = 32'h9ABC_DEF0;
      do_load(2, 1'b0);
      chk("t5_reload_done", done_cyc, 42);
      verify_image("t5", 2);

`ifdef IMEM_BOOT_CHECKSUM_EN
      wbuf[0] = 32'hFFFF_FFFF;
      wbuf[1] = 32'h0000_0002;
      do_load(2, 1'b0);
      chk("cs_wrap", checksum, 32'h0000_0001);
      step();
      chk("cs_stable", checksum, 32'h0000_0001);
`endif

      chk("ready_only_in_load", ready_bad, 0);
      chk("addr_below_depth", addr_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
